// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    // Values of i_parity_odd, latched per frame.
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count.
// The pointers carry one extra bit, so they wrap modulo 2*DEPTH.
// Full and empty come from the difference of the two pointers.
// A push while full and a pop while empty are ignored.
module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         push_ok;
    logic         pop_ok;

    assign o_count = wptr_q - rptr_q;
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign o_empty = (o_count == '0);
    assign o_data  = mem_q[rptr_q[AW-1:0]];

    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    // Pointer advance for accepted pushes and pops.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + (AW+1)'(1);
        if (pop_ok)  rptr_d = rptr_q + (AW+1)'(1);
    end

    // Pointer registers. Reset empties the FIFO.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array. It has no reset, because the pointers alone decide which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with a transmit FIFO.
// Frame: start, data bits (LSB first), optional parity, one or two stop bits.
// Optional feature macro: UART_TX_PARITY_EN.
// Without the macro, the PARITY state is removed and i_parity_odd is ignored.
//
// state  | meaning
// IDLE   | line high; pops the next byte when the FIFO holds one
// START  | line low for one bit time
// DATA   | shifts data_q out, LSB first, one bit time each
// PARITY | sends the parity of data_q (only with UART_TX_PARITY_EN)
// STOP   | line high for one or two bit times; o_done on the final cycle
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 651,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_BITS-1:0]          i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_parity_odd,
    input  logic                          i_two_stop,
    output logic                          o_tx_serial,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   stop2_q, stop2_d;
    logic [DATA_BITS-1:0]   data_q;
    logic                   two_stop_q;
    logic                   bit_tc;
    logic                   pop;
    logic                   tx;
    logic                   done;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_data;

`ifdef UART_TX_PARITY_EN
    logic                   par_odd_q;
    logic                   par_bit;
    assign par_bit = (^data_q) ^ (par_odd_q == PARITY_ODD);
`else
    logic                   unused_parity_odd;
    assign unused_parity_odd = i_parity_odd;
`endif

    uart_fifo #(
        .W     (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_valid),
        .i_data  (i_data),
        .i_pop   (pop),
        .o_data  (fifo_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (o_fifo_count)
    );

    assign o_ready     = !fifo_full;
    assign bit_tc      = (cnt_q == '0);
    assign o_tx_serial = tx;
    assign o_done      = done;
    assign o_busy      = (state_q != ST_IDLE);

    // Next state, bit timing, line level and pop decision.
    // A state change only happens at terminal count, so reloading the counter there also restarts it on every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_tc ? CNT_MAX : cnt_q - CNT_W'(1);
        idx_d   = idx_q;
        stop2_d = stop2_q;
        pop     = 1'b0;
        tx      = 1'b1;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_MAX;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (bit_tc) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                tx = data_q[idx_q];
                if (bit_tc) begin
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                        stop2_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx = par_bit;
                if (bit_tc) begin
                    state_d = ST_STOP;
                    stop2_d = 1'b0;
                end
            end
`endif
            ST_STOP: begin
                tx = 1'b1;
                if (bit_tc) begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        done    = 1'b1;
                        stop2_d = 1'b0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and bit-timer registers. Reset aborts any frame and returns the line to idle-high at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_MAX;
            idx_q   <= '0;
            stop2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop2_q <= stop2_d;
        end
    end

    // Per-frame latches. They are captured at the pop, so input changes during a frame only affect the next frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q     <= '0;
            two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_odd_q  <= PARITY_EVEN;
`endif
        end else if (pop) begin
            data_q     <= fifo_data;
            two_stop_q <= i_two_stop;
`ifdef UART_TX_PARITY_EN
            par_odd_q  <= i_parity_odd;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4).
// Expected frames are written out by hand for both builds (with and without UART_TX_PARITY_EN).
module tb_uart_tx_param;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       i_parity_odd;
    logic       i_two_stop;
    logic       o_tx_serial;
    logic       o_busy;
    logic       o_done;
    logic [2:0] o_fifo_count;

    int vectors;
    int miscompares;

    // Line levels in time order: bit 0 is the start bit.
`ifdef UART_TX_PARITY_EN
    localparam logic [11:0] F_A5       = 12'b010101001010; // 0xA5, even parity, 1 stop
    localparam int          N_A5       = 11;
    localparam logic [11:0] F_01_ODD2  = 12'b110000000010; // 0x01, odd parity (0), 2 stops
    localparam int          N_01_ODD2  = 12;
    localparam logic [11:0] F_01_EVEN1 = 12'b011000000010; // 0x01, even parity (1), 1 stop
    localparam int          N_01_EVEN1 = 11;
`else
    localparam logic [11:0] F_A5       = 12'b001101001010;
    localparam int          N_A5       = 10;
    localparam logic [11:0] F_01_ODD2  = 12'b011000000010;
    localparam int          N_01_ODD2  = 11;
    localparam logic [11:0] F_01_EVEN1 = 12'b001000000010;
    localparam int          N_01_EVEN1 = 10;
`endif

    uart_tx_param #(
        .CLKS_PER_BIT (4),
        .DATA_BITS    (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_parity_odd (i_parity_odd),
        .i_two_stop   (i_two_stop),
        .o_tx_serial  (o_tx_serial),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_fifo_count (o_fifo_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Presents one byte for one cycle and returns at the following negedge.
    task automatic push(input logic [7:0] d);
        i_valid = 1'b1;
        i_data  = d;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    // Checks the frame cycle by cycle, starting at the cycle after the pop.
    // It returns at the negedge of the o_done cycle.
    // With flip set, both frame options are inverted mid-frame; the frame must not react.
    task automatic check_frame(input string tag, input logic [11:0] bits, input int n, input bit flip);
        for (int k = 1; k <= n * 4; k++) begin
            @(negedge i_clk);
            if (flip && k == 2) begin
                i_parity_odd = ~i_parity_odd;
                i_two_stop   = ~i_two_stop;
            end
            check({tag, " line"}, o_tx_serial, bits[(k-1)/4]);
            check({tag, " busy"}, o_busy, 1'b1);
            check({tag, " done"}, o_done, (k == n * 4));
        end
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge i_clk);
            if (o_done) seen = 1'b1;
        end
    endtask

    bit seen;
    bit saw_done;
    bit saw_low;

    initial begin
        vectors      = 0;
        miscompares  = 0;
        i_rst        = 1'b1;
        i_valid      = 1'b0;
        i_data       = 8'h00;
        i_parity_odd = 1'b0;
        i_two_stop   = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst tx",    o_tx_serial,  1'b1);
        check("rst busy",  o_busy,       1'b0);
        check("rst done",  o_done,       1'b0);
        check("rst count", o_fifo_count, 3'd0);
        check("rst ready", o_ready,      1'b1);
        i_rst = 1'b0;
        @(negedge i_clk);

        // 0xA5, even parity, one stop bit
        push(8'hA5);
        check("a5 count at pop", o_fifo_count, 3'd1);
        check("a5 busy at pop",  o_busy,       1'b0);
        check_frame("a5", F_A5, N_A5, 1'b1);
        @(negedge i_clk);
        check("a5 idle busy", o_busy,      1'b0);
        check("a5 idle tx",   o_tx_serial, 1'b1);
        check("a5 idle done", o_done,      1'b0);
        check("a5 count",     o_fifo_count, 3'd0);

        // 0x01, odd parity, two stop bits
        i_parity_odd = 1'b1;
        i_two_stop   = 1'b1;
        push(8'h01);
        check_frame("01odd2", F_01_ODD2, N_01_ODD2, 1'b1);
        i_parity_odd = 1'b0;
        i_two_stop   = 1'b0;
        @(negedge i_clk);
        check("01odd2 idle busy", o_busy, 1'b0);

        // FIFO fill while a frame is running, then contiguous frames
        push(8'hA5);
        @(negedge i_clk);
        push(8'h01);
        check("fill c1", o_fifo_count, 3'd1);
        push(8'hA5);
        push(8'h01);
        push(8'hA5);
        check("fill c4",     o_fifo_count, 3'd4);
        check("fill ready",  o_ready,      1'b0);
        push(8'hFF);
        check("drop count",  o_fifo_count, 3'd4);
        check("drop ready",  o_ready,      1'b0);
        check("fill busy",   o_busy,       1'b1);
        wait_done(60, seen);
        check("fill first done", seen, 1'b1);
        check_frame("b2b0", F_01_EVEN1, N_01_EVEN1, 1'b0);
        check_frame("b2b1", F_A5,       N_A5,       1'b0);
        check_frame("b2b2", F_01_EVEN1, N_01_EVEN1, 1'b0);
        check_frame("b2b3", F_A5,       N_A5,       1'b0);
        @(negedge i_clk);
        check("b2b end busy",  o_busy,       1'b0);
        check("b2b end tx",    o_tx_serial,  1'b1);
        check("b2b end count", o_fifo_count, 3'd0);

        // Push on the same cycle as the back-to-back pop, with two entries queued
        push(8'h01);
        push(8'hA5);
        push(8'hA5);
        check("pp count 2", o_fifo_count, 3'd2);
        wait_done(60, seen);
        check("pp done seen", seen, 1'b1);
        check("pp count before", o_fifo_count, 3'd2);
        push(8'h01);
        check("pp count after", o_fifo_count, 3'd2);
        check("pp start line",  o_tx_serial,  1'b0);
        check("pp busy",        o_busy,       1'b1);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge i_clk);
            if (!o_busy) seen = 1'b1;
        end
        check("pp drained", seen, 1'b1);
        check("pp count 0", o_fifo_count, 3'd0);

        // Reset while data bit 3 is on the line
        push(8'hA5);
        push(8'h01);
        repeat (17) @(negedge i_clk);
        check("mid bit3 line", o_tx_serial,  1'b0);
        check("mid count",     o_fifo_count, 3'd1);
        i_rst = 1'b1;
        #1;
        check("abort tx",    o_tx_serial,  1'b1);
        check("abort busy",  o_busy,       1'b0);
        check("abort done",  o_done,       1'b0);
        check("abort count", o_fifo_count, 3'd0);
        check("abort ready", o_ready,      1'b1);
        @(negedge i_clk);
        i_rst = 1'b0;
        saw_done = 1'b0;
        saw_low  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge i_clk);
            if (o_done) saw_done = 1'b1;
            if (!o_tx_serial) saw_low = 1'b1;
        end
        check("post abort done", saw_done, 1'b0);
        check("post abort line", saw_low,  1'b0);
        check("post abort busy", o_busy,   1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 651, clock cycles per serial bit (>=2).
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame (5..9).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries (power of two, >=2).
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_data  input  DATA_BITS  byte to enqueue.
REQ-007 SHALL have port i_valid  input  1  enqueue request.
REQ-008 SHALL have port o_ready  output  1  FIFO not full.
REQ-009 SHALL have port i_parity_odd  input  1  0 even parity, 1 odd parity.
REQ-010 SHALL have port i_two_stop  input  1  0 one stop bit, 1 two stop bits.
REQ-011 SHALL have port o_tx_serial  output  1  serial line, idle high.
REQ-012 SHALL have port o_busy  output  1  frame in progress.
REQ-013 SHALL have port o_done  output  1  one-cycle end-of-frame pulse.
REQ-014 SHALL have port o_fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-015 SHALL write i_data on a cycle where i_valid && o_ready; i_valid while full SHALL be dropped with no state change.
REQ-016 SHALL keep o_fifo_count unchanged on simultaneous push and pop, and wrap pointers modulo 2*FIFO_DEPTH.
REQ-017 SHALL implement FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
REQ-018 SHALL pop in IDLE when FIFO non-empty, latching data, i_parity_odd and i_two_stop for the whole frame; later changes affect the next frame only.
REQ-019 SHALL drive o_tx_serial low starting the cycle after the pop, for exactly CLKS_PER_BIT cycles.
REQ-020 SHALL send DATA_BITS bits LSB first, each exactly CLKS_PER_BIT cycles.
REQ-021 SHALL compute parity as XOR of data bits (even), inverted when odd latched.
REQ-022 SHALL hold stop high for 1 or 2 bit times per latched i_two_stop.
REQ-023 SHALL pulse o_done on the last cycle of the final stop bit; if FIFO non-empty then, SHALL pop in that same cycle and start the next START with zero idle gap.
REQ-024 SHALL assert o_busy from the cycle after a pop through the o_done cycle inclusive, low otherwise.
REQ-025 SHALL restart the bit counter at every state transition; no sub-bit jitter across bits.

Reset
REQ-026 SHALL on i_rst, asynchronously: o_tx_serial=1, o_busy=0, o_done=0, FIFO emptied, o_fifo_count=0, o_ready=1, FSM IDLE.
REQ-027 SHALL abort a frame mid-transmission on reset, line high immediately; no o_done pulse for it.

Configuration
REQ-028 SHALL, with macro UART_TX_PARITY_EN defined, include PARITY state per REQ-021.
REQ-029 SHALL, without UART_TX_PARITY_EN, omit PARITY state and parity logic; i_parity_odd ignored; frame = start+data+stop.

Structure
REQ-030 SHALL place FSM state typedef and parity-mode constants in shared package uart_pkg.
REQ-031 SHALL implement the FIFO as sub-module uart_fifo (parametrised width/depth, count, full/empty).

Verification (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4)
REQ-032 SHALL push 0xA5, even, one stop, parity enabled -> line 0,1,0,1,0,0,1,0,1,0,1 each 4 cycles; o_done once at cycle 44 after pop.
REQ-033 SHALL push 0x01 with i_parity_odd=1, i_two_stop=1 -> parity bit 0, stop high 8 cycles, frame 48 cycles.
REQ-034 SHALL push 5 bytes back-to-back with no pop possible -> o_ready low after 4th, 5th dropped, o_fifo_count=4; frames then transmit contiguously with no idle cycle.
REQ-035 SHALL push during pop cycle with count=2 -> count stays 2.
REQ-036 SHALL assert i_rst at data bit 3 -> o_tx_serial=1 same cycle, o_busy=0, count=0, no o_done.
REQ-037 SHALL build without UART_TX_PARITY_EN, push 0xA5 -> 10-bit frame, 40 cycles, no parity bit.
